// File: rtl/msi_bus_request_sequencer.sv
// MSI bus request sequencer: captures one controller decision, runs the optional write-back
// beat and the coherence message on the snoopy bus, then commits the new line state.
// Optional macro ACK_TIMEOUT_EN adds a per-beat bus_ack timeout that aborts into ERR.
module msi_bus_request_sequencer #(
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       state_next_in,
    input  logic [1:0]       bus_next_in,
    input  logic             write_back_in,
    input  logic             no_bus_in,
    input  logic [TAG_W-1:0] req_tag,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic             bus_valid,
    output logic             bus_wb,
    output logic [1:0]       bus_op,
    output logic [TAG_W-1:0] bus_addr,
    input  logic             bus_ack,
    output logic             commit_valid,
    output logic [1:0]       commit_state,
    output logic             busy,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_WB     = 3'd2,
        S_MSG    = 3'd3,
        S_COMMIT = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [1:0] ENC_ILLEGAL = 2'b11;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // A decision is illegal if either encoded field that will be used is the reserved 11 code.
    function automatic logic decision_illegal(input logic [1:0] st, input logic [1:0] op,
                                              input logic nb);
        decision_illegal = (st == ENC_ILLEGAL) || (!nb && (op == ENC_ILLEGAL));
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         cap_state_r;
    logic [1:0]         cap_op_r;
    logic               cap_wb_r;
    logic [TAG_W-1:0]   cap_tag_r;
    logic [1:0]         cap_state_nxt_s;
    logic [1:0]         cap_op_nxt_s;
    logic [TAG_W-1:0]   cap_tag_nxt_s;
    logic               handshake_s;
    logic               timeout_s;

    logic               req_ready_nxt_s;
    logic               bus_req_nxt_s;
    logic               bus_valid_nxt_s;
    logic               bus_wb_nxt_s;
    logic [1:0]         bus_op_nxt_s;
    logic [TAG_W-1:0]   bus_addr_nxt_s;
    logic               commit_valid_nxt_s;
    logic [1:0]         commit_state_nxt_s;
    logic               busy_nxt_s;
    logic               error_nxt_s;

    logic               req_ready_r;
    logic               bus_req_r;
    logic               bus_valid_r;
    logic               bus_wb_r;
    logic [1:0]         bus_op_r;
    logic [TAG_W-1:0]   bus_addr_r;
    logic               commit_valid_r;
    logic [1:0]         commit_state_r;
    logic               busy_r;
    logic               error_r;

    assign handshake_s = req_valid && (state_r == S_IDLE);

`ifdef ACK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    assign timeout_s = (cnt_r == {CNT_W{1'b0}});

    // Per-beat ack watchdog: reloads on entry to each beat, counts down while no ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_nxt_s != state_r) &&
                     ((state_nxt_s == S_WB) || (state_nxt_s == S_MSG))) begin
            cnt_r <= CNT_LOAD;
        end else if (((state_r == S_WB) || (state_r == S_MSG)) && !bus_ack && !timeout_s) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Decision capture at the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state_r <= 2'b00;
            cap_op_r    <= 2'b00;
            cap_wb_r    <= 1'b0;
            cap_tag_r   <= {TAG_W{1'b0}};
        end else if (handshake_s) begin
            cap_state_r <= state_next_in;
            cap_op_r    <= bus_next_in;
            cap_wb_r    <= write_back_in;
            cap_tag_r   <= req_tag;
        end else begin
            cap_state_r <= cap_state_r;
            cap_op_r    <= cap_op_r;
            cap_wb_r    <= cap_wb_r;
            cap_tag_r   <= cap_tag_r;
        end
    end

    // Captured values as they will be after this edge, so outputs can be registered.
    always_comb begin
        if (handshake_s) begin
            cap_state_nxt_s = state_next_in;
            cap_op_nxt_s    = bus_next_in;
            cap_tag_nxt_s   = req_tag;
        end else begin
            cap_state_nxt_s = cap_state_r;
            cap_op_nxt_s    = cap_op_r;
            cap_tag_nxt_s   = cap_tag_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; grant loss after ARB is ignored because the bus is locked.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!req_valid) begin
                    state_nxt_s = S_IDLE;
                end else if (decision_illegal(state_next_in, bus_next_in, no_bus_in)) begin
                    state_nxt_s = S_ERR;
                end else if (no_bus_in) begin
                    state_nxt_s = S_COMMIT;
                end else begin
                    state_nxt_s = S_ARB;
                end
            end
            S_ARB: begin
                if (!bus_grant) begin
                    state_nxt_s = S_ARB;
                end else if (cap_wb_r) begin
                    state_nxt_s = S_WB;
                end else begin
                    state_nxt_s = S_MSG;
                end
            end
            S_WB: begin
                if (bus_ack) begin
                    state_nxt_s = S_MSG;
                end else if (timeout_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_WB;
                end
            end
            S_MSG: begin
                if (bus_ack) begin
                    state_nxt_s = S_COMMIT;
                end else if (timeout_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_MSG;
                end
            end
            S_COMMIT: state_nxt_s = S_IDLE;
            S_ERR:    state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below.
    always_comb begin
        req_ready_nxt_s    = 1'b0;
        bus_req_nxt_s      = 1'b0;
        bus_valid_nxt_s    = 1'b0;
        bus_wb_nxt_s       = 1'b0;
        bus_op_nxt_s       = 2'b00;
        bus_addr_nxt_s     = {TAG_W{1'b0}};
        commit_valid_nxt_s = 1'b0;
        commit_state_nxt_s = 2'b00;
        busy_nxt_s         = 1'b1;
        error_nxt_s        = 1'b0;
        case (state_nxt_s)
            S_IDLE: begin
                req_ready_nxt_s = 1'b1;
                busy_nxt_s      = 1'b0;
            end
            S_ARB: begin
                bus_req_nxt_s = 1'b1;
            end
            S_WB: begin
                bus_req_nxt_s   = 1'b1;
                bus_valid_nxt_s = 1'b1;
                bus_wb_nxt_s    = 1'b1;
                bus_addr_nxt_s  = cap_tag_nxt_s;
            end
            S_MSG: begin
                bus_req_nxt_s   = 1'b1;
                bus_valid_nxt_s = 1'b1;
                bus_op_nxt_s    = cap_op_nxt_s;
                bus_addr_nxt_s  = cap_tag_nxt_s;
            end
            S_COMMIT: begin
                commit_valid_nxt_s = 1'b1;
                commit_state_nxt_s = cap_state_nxt_s;
            end
            S_ERR: begin
                error_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b1;
            end
        endcase
    end

    // Output registers; reset releases the bus immediately and abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r    <= 1'b1;
            bus_req_r      <= 1'b0;
            bus_valid_r    <= 1'b0;
            bus_wb_r       <= 1'b0;
            bus_op_r       <= 2'b00;
            bus_addr_r     <= {TAG_W{1'b0}};
            commit_valid_r <= 1'b0;
            commit_state_r <= 2'b00;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            req_ready_r    <= req_ready_nxt_s;
            bus_req_r      <= bus_req_nxt_s;
            bus_valid_r    <= bus_valid_nxt_s;
            bus_wb_r       <= bus_wb_nxt_s;
            bus_op_r       <= bus_op_nxt_s;
            bus_addr_r     <= bus_addr_nxt_s;
            commit_valid_r <= commit_valid_nxt_s;
            commit_state_r <= commit_state_nxt_s;
            busy_r         <= busy_nxt_s;
            error_r        <= error_nxt_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign bus_req      = bus_req_r;
    assign bus_valid    = bus_valid_r;
    assign bus_wb       = bus_wb_r;
    assign bus_op       = bus_op_r;
    assign bus_addr     = bus_addr_r;
    assign commit_valid = commit_valid_r;
    assign commit_state = commit_state_r;
    assign busy         = busy_r;
    assign error        = error_r;

endmodule

// File: tb/tb_msi_bus_request_sequencer.sv
// Directed self-checking bench for msi_bus_request_sequencer (timeout case when ACK_TIMEOUT_EN is set).
module tb_msi_bus_request_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] state_next_in;
    logic [1:0] bus_next_in;
    logic       write_back_in;
    logic       no_bus_in;
    logic [7:0] req_tag;
    logic       bus_req;
    logic       bus_grant;
    logic       bus_valid;
    logic       bus_wb;
    logic [1:0] bus_op;
    logic [7:0] bus_addr;
    logic       bus_ack;
    logic       commit_valid;
    logic [1:0] commit_state;
    logic       busy;
    logic       error;

    int tests = 0;
    int fails = 0;

    msi_bus_request_sequencer #(.TAG_W(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .state_next_in(state_next_in), .bus_next_in(bus_next_in),
        .write_back_in(write_back_in), .no_bus_in(no_bus_in), .req_tag(req_tag),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_valid(bus_valid),
        .bus_wb(bus_wb), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
        .commit_valid(commit_valid), .commit_state(commit_state),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic [1:0] op,
                         input logic wb, input logic nb, input logic [7:0] tg);
        req_valid     = v;
        state_next_in = st;
        bus_next_in   = op;
        write_back_in = wb;
        no_bus_in     = nb;
        req_tag       = tg;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        bus_grant = 1'b0;
        bus_ack   = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_busy_err", {busy, error, bus_wb, bus_op, bus_addr, commit_state}, 0);
        #4 rst_n = 1'b1;
        tick();

        // no_bus hit with reserved bus code that must be ignored
        drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 8'h55);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        check("nobus_commit_valid", commit_valid, 1);
        check("nobus_commit_state", commit_state, 2'b01);
        check("nobus_bus_req", bus_req, 0);
        check("nobus_error", error, 0);
        check("nobus_ready", req_ready, 0);
        tick();
        check("nobus_commit_drop", commit_valid, 0);
        check("nobus_idle_ready", req_ready, 1);

        // read miss, immediate grant and ack (ack ignored in ARB)
        bus_grant = 1'b1;
        bus_ack   = 1'b1;
        drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 8'h3C);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        check("rm_arb_req", bus_req, 1);
        check("rm_arb_valid", bus_valid, 0);
        check("rm_arb_busy", busy, 1);
        tick();
        check("rm_msg_valid", bus_valid, 1);
        check("rm_msg_op", bus_op, 2'b10);
        check("rm_msg_addr", bus_addr, 8'h3C);
        check("rm_msg_wb", bus_wb, 0);
        tick();
        check("rm_commit", {commit_valid, commit_state}, 3'b110);
        check("rm_commit_bus", {bus_req, bus_valid, bus_op, bus_addr}, 0);
        bus_grant = 1'b0;
        bus_ack   = 1'b0;
        tick();
        check("rm_idle", {req_ready, busy, commit_valid}, 3'b100);

        // write miss with write-back, late grant, slow acks, grant drop mid-WB
        drive(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        check("wm_arb1", {bus_req, bus_valid}, 2'b10);
        tick();
        check("wm_arb2", {bus_req, bus_valid}, 2'b10);
        tick();
        check("wm_arb3", {bus_req, bus_valid}, 2'b10);
        bus_grant = 1'b1;
        tick();
        check("wm_wb_beat", {bus_req, bus_valid, bus_wb, bus_op}, 5'b11100);
        check("wm_wb_addr", bus_addr, 8'hA5);
        bus_grant = 1'b0;
        tick();
        check("wm_wb_hold", {bus_req, bus_valid, bus_wb, bus_op, bus_addr}, {5'b11100, 8'hA5});
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("wm_msg_beat", {bus_req, bus_valid, bus_wb, bus_op}, 5'b11001);
        check("wm_msg_addr", bus_addr, 8'hA5);
        tick();
        check("wm_msg_hold", {bus_req, bus_valid, bus_wb, bus_op}, 5'b11001);
        check("wm_no_early_commit", commit_valid, 0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("wm_commit", {commit_valid, commit_state, bus_req}, 4'b1010);
        tick();
        check("wm_commit_once", commit_valid, 0);
        check("wm_ready", req_ready, 1);

        // illegal state code, then a legal request in the following idle cycle
        drive(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 8'h01);
        tick();
        check("ill_error", error, 1);
        check("ill_no_bus", {bus_req, commit_valid, req_ready}, 0);
        drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 8'h02);
        tick();
        check("ill_err_drop", error, 0);
        check("ill_ready_again", req_ready, 1);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        check("ill_next_commit", {commit_valid, commit_state}, 3'b110);
        tick();

        // illegal bus code on a bus-using request
        drive(1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 8'h03);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        check("ill_op_error", {error, bus_req, commit_valid}, 3'b100);
        tick();

        // asynchronous reset while the message beat is on the bus
        bus_grant = 1'b1;
        drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 8'h11);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        check("rmid_in_msg", bus_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rmid_bus_req", bus_req, 0);
        check("rmid_bus_valid", bus_valid, 0);
        check("rmid_ready", req_ready, 1);
        bus_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rmid_no_commit1", {commit_valid, error, bus_req}, 0);
        tick();
        check("rmid_no_commit2", {commit_valid, error, bus_req}, 0);
        bus_ack   = 1'b0;
        bus_grant = 1'b1;

        // message beat with no ack
        drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h77);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        check("to_msg1", bus_valid, 1);
        tick();
        tick();
        tick();
        check("to_msg4", {bus_req, bus_valid, bus_op}, 4'b1101);
        tick();
`ifdef ACK_TIMEOUT_EN
        check("to_error", error, 1);
        check("to_bus_req", {bus_req, bus_valid}, 0);
        check("to_no_commit", commit_valid, 0);
        tick();
        check("to_idle", {req_ready, error, commit_valid}, 3'b100);
`else
        for (int i = 0; i < 10; i++) tick();
        check("wait_still_msg", {bus_req, bus_valid, bus_op, bus_addr}, {4'b1101, 8'h77});
        check("wait_no_error", error, 0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("wait_commit", {commit_valid, commit_state}, 3'b101);
        tick();
        check("wait_idle", req_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msi_bus_request_sequencer.md
Name: msi_bus_request_sequencer

Overview:
- Sequential stage directly downstream of the MSI CPU-request controller.
- Captures one request decision from that controller: next line state, bus message and write-back flag.
- Arbitrates for the shared snoopy bus, issues the write-back beat first when required, then the coherence message.
- After the bus completes, commits the new MSI state to the line-state register. One request is in flight at a time.

Parameters:
- TAG_W, 8, width of the block tag/address carried with the request onto the bus.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for bus_ack per beat; used only when ACK_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  controller decision valid.
- req_ready  output  1  sequencer can accept a decision.
- state_next_in  input  2  next MSI state (INVALID=00, MODIFIED=01, SHARED=10, 11=error).
- bus_next_in  input  2  bus message (INVALIDATE=00, WRITE_MISS=01, READ_MISS=10, 11=error).
- write_back_in  input  1  dirty block must be written back before the message.
- no_bus_in  input  1  hit needing no bus transaction; bus_next_in is ignored.
- req_tag  input  TAG_W  block tag of the request.
- bus_req  output  1  request/hold of the shared bus.
- bus_grant  input  1  arbiter grant.
- bus_valid  output  1  beat on bus is valid.
- bus_wb  output  1  current beat is a write-back (data) beat.
- bus_op  output  2  coherence message of the current beat; 00 during a write-back beat.
- bus_addr  output  TAG_W  tag of the current beat.
- bus_ack  input  1  bus accepted/completed the current beat.
- commit_valid  output  1  one-cycle pulse: write commit_state to the line.
- commit_state  output  2  MSI state to commit.
- busy  output  1  high whenever the FSM is not in IDLE.
- error  output  1  one-cycle pulse on an illegal decision or a timeout.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE immediately.
  - Every output is 0 except req_ready=1.
  - Captured state/op/wb/tag registers are cleared to 0.
  - Reset mid-transaction abandons the transaction: no commit and no error pulse. The bus is released at once because bus_req drops to 0.
- req_ready = (FSM==IDLE). A handshake occurs when req_valid&&req_ready at a rising edge; the inputs are captured at that edge.
- FSM states: IDLE, ARB, WB, MSG, COMMIT, ERR.
- IDLE -> ERR if state_next_in==11, or if bus_next_in==11 with no_bus_in=0.
- IDLE -> COMMIT if no_bus_in=1.
- IDLE -> ARB otherwise.
- ARB:
  - bus_req=1.
  - If bus_grant is sampled 1: go to WB when write_back was captured, else MSG.
  - bus_ack is ignored in ARB.
- WB:
  - bus_req=1, bus_valid=1, bus_wb=1, bus_op=00, bus_addr=tag.
  - Stays until bus_ack=1, then goes to MSG.
- MSG:
  - bus_req=1, bus_valid=1, bus_wb=0, bus_op=captured op, bus_addr=tag.
  - Stays until bus_ack=1, then goes to COMMIT.
- Bus lock: bus_req stays high from ARB through the MSG ack. A grant deassertion during WB or MSG is ignored.
- COMMIT: commit_valid=1 and commit_state=captured state for exactly one cycle, then IDLE.
- ERR: error=1 for one cycle with no bus activity and no commit, then IDLE.
- Latency, with request accepted at edge N:
  - no_bus request: commit pulse in cycle N+1.
  - Bus request with immediate grant and ack: ARB N+1, MSG N+2, COMMIT N+3.
  - With write-back inserted: COMMIT N+4.
- Each wait state holds indefinitely; bus outputs stay stable while bus_valid=1 and bus_ack=0.
- Outside ARB/WB/MSG, bus_valid, bus_wb and bus_req are 0, and bus_op/bus_addr are 0.

Optional Feature:
- Macro ACK_TIMEOUT_EN.
- When defined:
  - A down-counter loads TIMEOUT_CYCLES-1 on entry to WB and again on entry to MSG.
  - The counter decrements each cycle without bus_ack.
  - If the counter reaches 0 without an ack, the FSM goes to ERR: bus_req drops next cycle, error pulses, no commit.
  - An ack in the same cycle as count 0 counts as success.
- When undefined: no counter logic; WB and MSG wait forever.

Test Plan:
- Reset mid-MSG: rst_n low while bus_valid=1 -> same cycle bus_req=0, bus_valid=0, req_ready=1; no commit_valid afterwards.
- no_bus_in=1, state_next_in=01 accepted at N -> commit_valid=1, commit_state=01 at N+1; bus_req never asserted.
- INVALID read miss: state_next_in=10, bus_next_in=10, tag=0x3C, grant and ack immediate -> bus_valid at N+2 with bus_op=10, bus_addr=0x3C; commit_state=10 at N+3.
- MODIFIED write miss: write_back_in=1, bus_next_in=01; grant delayed 3 cycles; ack delayed 2 cycles per beat; grant drops mid-WB -> WB beat (bus_wb=1) then MSG beat (op 01); bus_req continuous; commit_state=01 once.
- Illegal decision: state_next_in=11 -> error pulse at N+1, no bus_req, no commit; next request accepted at N+2.
- ACK_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, bus_ack held 0 in MSG -> error pulse after 4 MSG cycles, bus_req low, no commit.
